pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Multi-cycle fetch/execute sequencer for the 9-bit-instruction core.
- Owns the PC and instruction register, and handshakes instruction and data memory.
- Consumes decoded control flags (branch, jump, halt, mem read/write, reg write) from the decoder and gates register writes to one commit pulse per instruction.
- Sits between instruction memory, the decoder/ALU datapath and data memory.

Parameters:
PC_W, 10, program counter / instruction address width
INSTR_W, 9, instruction width
CNT_W, 16, executed-cycle counter width

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  begin execution from address 0 (level, sampled in IDLE/HALT)
imem_req  out  1  instruction fetch request
imem_addr  out  PC_W  fetch address (= pc)
imem_ready  in  1  fetch data valid this cycle
imem_data  in  INSTR_W  fetched instruction
instr  out  INSTR_W  instruction register, drives decoder
exec_valid  out  1  high in EXEC: decoder flags below are meaningful
branch  in  1  decoded conditional branch
branch_taken  in  1  ALU compare result for current instruction
jmp_ctrl  in  1  decoded unconditional jump
done_ctrl  in  1  decoded halt
mem_read  in  1  decoded load
mem_write  in  1  decoded store
reg_write  in  1  decoded register write
target_addr  in  PC_W  branch/jump target from datapath
dmem_req  out  1  data memory request
dmem_we  out  1  1 = store, 0 = load (valid while dmem_req)
dmem_ready  in  1  data access complete
reg_write_en  out  1  one-cycle register-file commit strobe
pc  out  PC_W  current program counter
busy  out  1  state is FETCH, EXEC or MEM
halted  out  1  state is HALT
cycle_count  out  CNT_W  cycles spent busy since last start

Behaviour:
- Reset (async, reset_n=0) forces IDLE, pc=0, instr=0, cycle_count=0. All outputs are 0.
  - Any in-flight imem/dmem request is dropped immediately.
- States: IDLE, FETCH, EXEC, MEM, HALT. The state register updates on the rising clock edge.
- IDLE: start=1 -> FETCH next cycle; pc=0; cycle_count=0.
- FETCH: imem_req=1, imem_addr=pc.
  - imem_ready=1 (including the first cycle of FETCH) -> instr<=imem_data, go to EXEC.
  - Otherwise stay in FETCH.
- EXEC: exactly one cycle, exec_valid=1. Priority is done_ctrl > memory > normal.
  - done_ctrl=1 -> HALT. No commit, no dmem_req, pc unchanged.
  - mem_read|mem_write -> MEM. dmem_we=mem_write, latched at EXEC exit and held through MEM.
  - Otherwise -> FETCH with commit.
- MEM: dmem_req=1 until dmem_ready=1, then commit and go to FETCH.
  - Same-cycle dmem_ready is accepted on the first MEM cycle.
- Commit (the cycle leaving EXEC or MEM):
  - reg_write_en = reg_write, as latched in EXEC.
  - pc <= next_pc.
- next_pc:
  - jmp_ctrl=1 -> target_addr (jump wins over branch when both are set).
  - Else branch & branch_taken -> target_addr.
  - Else pc+1, modulo 2^PC_W (all-ones wraps to 0).
- Decoder flags are sampled only in EXEC. In FETCH/MEM they are don't-care; x values there must not propagate.
- HALT: halted=1, pc and cycle_count frozen. start=1 -> FETCH with pc=0 and cycle_count=0.
- cycle_count increments every cycle busy=1 and saturates at all-ones.
- reg_write_en is never asserted outside the commit cycle. At most one pulse per instruction.

Decomposition:
- Shared package: state encoding enum (IDLE=0, FETCH=1, EXEC=2, MEM=3, HALT=4) and PC_W/INSTR_W defaults, shared with the decoder and testbench.
- next-PC selection can live in a small combinational sub-module, pc_next_sel. Everything else stays in pc_sequencer.

Test Plan:
- Reset, then start=1, imem_ready tied 1, program of three ADDs (reg_write=1) -> pc goes 0,1,2,3. reg_write_en pulses once per instruction every 2 cycles. cycle_count=6 after the third commit.
- Fetch with imem_ready delayed 3 cycles -> imem_req held 4 cycles with imem_addr stable. instr loads only on the ready cycle.
- Load at pc=5, dmem_ready after 2 cycles -> dmem_req=1 for 2 cycles with dmem_we=0. reg_write_en pulses on the ready cycle. pc becomes 6.
- At pc=7:
  - beq taken with target_addr=0x020 -> pc=0x020.
  - Not taken -> pc=8.
  - jmp_ctrl=1 and branch=1 with target=0x3FF -> pc=0x3FF. The next sequential instruction wraps pc to 0.
- Halt at pc=4 -> halted=1, no reg_write_en, pc stays 4. A later start=1 restarts fetch at pc=0 with cycle_count=0.
- Assert reset_n=0 mid-MEM with dmem_req high -> dmem_req, busy and reg_write_en drop asynchronously. pc=0 and state IDLE after release.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the 9-bit-instruction core sequencer.
// The decoder and the testbench use the same state encoding and width defaults.
package pc_sequencer_pkg;

   localparam int PC_W_DEF    = 10;
   localparam int INSTR_W_DEF = 9;
   localparam int CNT_W_DEF   = 16;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_EXEC  = 3'd2,
      ST_MEM   = 3'd3,
      ST_HALT  = 3'd4
   } seq_state_e;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection: a jump beats a taken branch, and a taken branch beats
// sequential flow. Sequential flow wraps modulo 2^PC_W.
module pc_next_sel
   import pc_sequencer_pkg::*;
#(
   parameter int PC_W = PC_W_DEF
) (
   input  logic [PC_W-1:0] pc,
   input  logic            jmp_ctrl,
   input  logic            branch,
   input  logic            branch_taken,
   input  logic [PC_W-1:0] target_addr,
   output logic [PC_W-1:0] next_pc
);

   always_comb begin
      next_pc = pc + PC_W'(1);
      if (jmp_ctrl || (branch && branch_taken)) begin
         next_pc = target_addr;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/execute sequencer: owns the PC and instruction register,
// handshakes both memories, and emits one register-file commit per instruction.
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter int PC_W    = PC_W_DEF,
   parameter int INSTR_W = INSTR_W_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               start,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic               imem_ready,
   input  logic [INSTR_W-1:0] imem_data,
   output logic [INSTR_W-1:0] instr,
   output logic               exec_valid,
   input  logic               branch,
   input  logic               branch_taken,
   input  logic               jmp_ctrl,
   input  logic               done_ctrl,
   input  logic               mem_read,
   input  logic               mem_write,
   input  logic               reg_write,
   input  logic [PC_W-1:0]    target_addr,
   output logic               dmem_req,
   output logic               dmem_we,
   input  logic               dmem_ready,
   output logic               reg_write_en,
   output logic [PC_W-1:0]    pc,
   output logic               busy,
   output logic               halted,
   output logic [CNT_W-1:0]   cycle_count
);

   seq_state_e         state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [PC_W-1:0]    pend_pc_q, pend_pc_d;
   logic [PC_W-1:0]    exec_next_pc;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               we_q, we_d;
   logic               rw_q, rw_d;
   logic               exec_commit;
   logic               mem_commit;
   logic               busy_w;

   pc_next_sel #(.PC_W(PC_W)) u_pc_next_sel (
      .pc           (pc_q),
      .jmp_ctrl     (jmp_ctrl),
      .branch       (branch),
      .branch_taken (branch_taken),
      .target_addr  (target_addr),
      .next_pc      (exec_next_pc)
   );

   assign busy_w = (state_q == ST_FETCH) || (state_q == ST_EXEC) || (state_q == ST_MEM);

   // Decoder flags are looked at only in EXEC; a memory instruction carries
   // its commit information (next PC, reg_write, store/load) into MEM.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      pend_pc_d   = pend_pc_q;
      instr_d     = instr_q;
      cnt_d       = cnt_q;
      we_d        = we_q;
      rw_d        = rw_q;
      exec_commit = 1'b0;
      mem_commit  = 1'b0;

      if (busy_w && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      case (state_q)
         ST_IDLE, ST_HALT: begin
            if (start) begin
               state_d = ST_FETCH;
               pc_d    = '0;
               cnt_d   = '0;
            end
         end
         ST_FETCH: begin
            if (imem_ready) begin
               instr_d = imem_data;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (done_ctrl) begin
               state_d = ST_HALT;
            end else if (mem_read || mem_write) begin
               state_d   = ST_MEM;
               we_d      = mem_write;
               rw_d      = reg_write;
               pend_pc_d = exec_next_pc;
            end else begin
               state_d     = ST_FETCH;
               exec_commit = 1'b1;
               pc_d        = exec_next_pc;
            end
         end
         ST_MEM: begin
            if (dmem_ready) begin
               state_d    = ST_FETCH;
               mem_commit = 1'b1;
               pc_d       = pend_pc_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         pc_q      <= '0;
         pend_pc_q <= '0;
         instr_q   <= '0;
         cnt_q     <= '0;
         we_q      <= 1'b0;
         rw_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         pend_pc_q <= pend_pc_d;
         instr_q   <= instr_d;
         cnt_q     <= cnt_d;
         we_q      <= we_d;
         rw_q      <= rw_d;
      end
   end

   assign imem_req     = (state_q == ST_FETCH);
   assign imem_addr    = pc_q;
   assign instr        = instr_q;
   assign exec_valid   = (state_q == ST_EXEC);
   assign dmem_req     = (state_q == ST_MEM);
   assign dmem_we      = (state_q == ST_MEM) && we_q;
   assign reg_write_en = (exec_commit && reg_write) || (mem_commit && rw_q);
   assign pc           = pc_q;
   assign busy         = busy_w;
   assign halted       = (state_q == ST_HALT);
   assign cycle_count  = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a directed program table, randomized
// instructions against a reference model, and an asynchronous reset mid-MEM.
module tb_pc_sequencer;

   localparam int PC_W     = 10;
   localparam int INSTR_W  = 9;
   localparam int TB_CNT_W = 5;
   localparam int CMAX     = (1 << TB_CNT_W) - 1;

   typedef struct {
      int                 imem_dly;
      logic [INSTR_W-1:0] data;
      bit                 done, mrd, mwr, rw, br, tk, jmp;
      logic [PC_W-1:0]    tgt;
      int                 dmem_dly;
      logic [PC_W-1:0]    exp_pc;
   } vec_t;

   logic                clock = 1'b0;
   logic                reset_n;
   logic                start;
   logic                imem_req;
   logic [PC_W-1:0]     imem_addr;
   logic                imem_ready;
   logic [INSTR_W-1:0]  imem_data;
   logic [INSTR_W-1:0]  instr;
   logic                exec_valid;
   logic                branch, branch_taken, jmp_ctrl, done_ctrl;
   logic                mem_read, mem_write, reg_write;
   logic [PC_W-1:0]     target_addr;
   logic                dmem_req, dmem_we, dmem_ready;
   logic                reg_write_en;
   logic [PC_W-1:0]     pc;
   logic                busy, halted;
   logic [TB_CNT_W-1:0] cycle_count;

   int                  n_checks = 0;
   int                  n_errors = 0;
   logic [PC_W-1:0]     m_pc;
   logic [INSTR_W-1:0]  m_instr;
   int                  m_cnt;
   vec_t                tbl[$];

   pc_sequencer #(.PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(TB_CNT_W)) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .start        (start),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ready   (imem_ready),
      .imem_data    (imem_data),
      .instr        (instr),
      .exec_valid   (exec_valid),
      .branch       (branch),
      .branch_taken (branch_taken),
      .jmp_ctrl     (jmp_ctrl),
      .done_ctrl    (done_ctrl),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .reg_write    (reg_write),
      .target_addr  (target_addr),
      .dmem_req     (dmem_req),
      .dmem_we      (dmem_we),
      .dmem_ready   (dmem_ready),
      .reg_write_en (reg_write_en),
      .pc           (pc),
      .busy         (busy),
      .halted       (halted),
      .cycle_count  (cycle_count)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [PC_W-1:0] model_next(input logic [PC_W-1:0] cur, input vec_t v);
      if (v.jmp) return v.tgt;
      if (v.br && v.tk) return v.tgt;
      return PC_W'((int'(cur) + 1) % (1 << PC_W));
   endfunction

   function automatic vec_t mk(input int idly, input bit done, input bit mrd, input bit mwr,
                               input bit rw, input bit br, input bit tk, input bit jmp,
                               input logic [PC_W-1:0] tgt, input int ddly,
                               input logic [PC_W-1:0] exp_pc);
      vec_t v;
      v.imem_dly = idly; v.data = INSTR_W'($urandom);
      v.done = done; v.mrd = mrd; v.mwr = mwr; v.rw = rw;
      v.br = br; v.tk = tk; v.jmp = jmp; v.tgt = tgt;
      v.dmem_dly = ddly; v.exp_pc = exp_pc;
      return v;
   endfunction

   task automatic scramble_flags();
      branch       = 1'($urandom);
      branch_taken = 1'($urandom);
      jmp_ctrl     = 1'($urandom);
      done_ctrl    = 1'($urandom);
      mem_read     = 1'($urandom);
      mem_write    = 1'($urandom);
      reg_write    = 1'($urandom);
      target_addr  = PC_W'($urandom);
   endtask

   task automatic next_cycle(input bit counts);
      @(posedge clock);
      if (counts && m_cnt < CMAX) m_cnt++;
      @(negedge clock);
   endtask

   // Called at a falling edge in IDLE or HALT; returns at the first FETCH falling edge.
   task automatic do_start();
      start = 1'b1;
      #1;
      checkOutput("start_busy_before", 32'(busy), 32'd0);
      next_cycle(1'b0);
      start = 1'b0;
      m_pc  = '0;
      m_cnt = 0;
   endtask

   // Called at a falling edge in FETCH; runs one instruction through to its end.
   task automatic applyStimulus(input vec_t v);
      bit exp_rwen;
      for (int i = 0; i <= v.imem_dly; i++) begin
         scramble_flags();
         imem_ready = (i == v.imem_dly);
         imem_data  = (i == v.imem_dly) ? v.data : INSTR_W'($urandom);
         dmem_ready = 1'($urandom);
         #1;
         checkOutput("fetch_req", 32'(imem_req), 32'd1);
         checkOutput("fetch_addr", 32'(imem_addr), 32'(m_pc));
         checkOutput("fetch_pc", 32'(pc), 32'(m_pc));
         checkOutput("fetch_instr_hold", 32'(instr), 32'(m_instr));
         checkOutput("fetch_busy", 32'(busy), 32'd1);
         checkOutput("fetch_exec_valid", 32'(exec_valid), 32'd0);
         checkOutput("fetch_dmem_req", 32'(dmem_req), 32'd0);
         checkOutput("fetch_rwen", 32'(reg_write_en), 32'd0);
         checkOutput("fetch_cnt", 32'(cycle_count), 32'(m_cnt));
         next_cycle(1'b1);
      end
      m_instr = v.data;

      imem_ready   = 1'($urandom);
      imem_data    = INSTR_W'($urandom);
      dmem_ready   = 1'($urandom);
      branch       = v.br;
      branch_taken = v.tk;
      jmp_ctrl     = v.jmp;
      done_ctrl    = v.done;
      mem_read     = v.mrd;
      mem_write    = v.mwr;
      reg_write    = v.rw;
      target_addr  = v.tgt;
      exp_rwen     = !v.done && !(v.mrd || v.mwr) && v.rw;
      #1;
      checkOutput("exec_instr", 32'(instr), 32'(v.data));
      checkOutput("exec_valid", 32'(exec_valid), 32'd1);
      checkOutput("exec_imem_req", 32'(imem_req), 32'd0);
      checkOutput("exec_dmem_req", 32'(dmem_req), 32'd0);
      checkOutput("exec_rwen", 32'(reg_write_en), 32'(exp_rwen));
      checkOutput("exec_cnt", 32'(cycle_count), 32'(m_cnt));
      next_cycle(1'b1);

      if (v.done) begin
         checkOutput("halt_halted", 32'(halted), 32'd1);
         checkOutput("halt_busy", 32'(busy), 32'd0);
         checkOutput("halt_pc", 32'(pc), 32'(v.exp_pc));
         checkOutput("halt_rwen", 32'(reg_write_en), 32'd0);
         checkOutput("halt_imem_req", 32'(imem_req), 32'd0);
         return;
      end

      if (v.mrd || v.mwr) begin
         for (int j = 0; j <= v.dmem_dly; j++) begin
            scramble_flags();
            imem_ready = 1'($urandom);
            dmem_ready = (j == v.dmem_dly);
            #1;
            checkOutput("mem_req", 32'(dmem_req), 32'd1);
            checkOutput("mem_we", 32'(dmem_we), 32'(v.mwr));
            checkOutput("mem_pc", 32'(pc), 32'(m_pc));
            checkOutput("mem_imem_req", 32'(imem_req), 32'd0);
            checkOutput("mem_rwen", 32'(reg_write_en), 32'((j == v.dmem_dly) && v.rw));
            checkOutput("mem_cnt", 32'(cycle_count), 32'(m_cnt));
            next_cycle(1'b1);
         end
      end
      m_pc = v.exp_pc;
   endtask

   initial begin
      vec_t v;
      int   r;
      reset_n = 1'b0; start = 1'b0; imem_ready = 1'b0; imem_data = '0; dmem_ready = 1'b0;
      scramble_flags();
      m_pc = '0; m_instr = '0; m_cnt = 0;

      @(negedge clock);
      @(negedge clock);
      #1;
      checkOutput("rst_imem_req", 32'(imem_req), 32'd0);
      checkOutput("rst_dmem_req", 32'(dmem_req), 32'd0);
      checkOutput("rst_pc", 32'(pc), 32'd0);
      checkOutput("rst_instr", 32'(instr), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_halted", 32'(halted), 32'd0);
      checkOutput("rst_cnt", 32'(cycle_count), 32'd0);
      checkOutput("rst_rwen", 32'(reg_write_en), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);

      // Directed program: ADDs, slow fetch, load/store, branches, jump wrap, halt.
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 10'h000, 0, 10'h001));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 10'h000, 0, 10'h002));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 10'h000, 0, 10'h003));
      tbl.push_back(mk(3, 0, 0, 0, 1, 0, 0, 0, 10'h000, 0, 10'h004));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 10'h000, 0, 10'h005));
      tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, 10'h000, 1, 10'h006));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 10'h000, 0, 10'h007));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 10'h020, 0, 10'h020));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 10'h007, 0, 10'h007));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 10'h055, 0, 10'h008));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 10'h007, 0, 10'h007));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 10'h3FF, 0, 10'h3FF));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 10'h000, 0, 10'h000));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 10'h004, 0, 10'h004));
      tbl.push_back(mk(0, 1, 1, 0, 1, 0, 0, 0, 10'h000, 0, 10'h004));

      do_start();
      for (int i = 0; i < tbl.size(); i++) begin
         applyStimulus(tbl[i]);
         if (i == 2) begin
            checkOutput("three_adds_cnt", 32'(cycle_count), 32'd6);
            checkOutput("three_adds_pc", 32'(pc), 32'd3);
         end
      end
      checkOutput("cnt_saturated", 32'(cycle_count), 32'(CMAX));
      for (int k = 0; k < 2; k++) begin
         next_cycle(1'b0);
         checkOutput("halt_hold_pc", 32'(pc), 32'd4);
         checkOutput("halt_hold_cnt", 32'(cycle_count), 32'(CMAX));
         checkOutput("halt_hold_halted", 32'(halted), 32'd1);
      end
      do_start();
      checkOutput("restart_pc", 32'(pc), 32'd0);
      checkOutput("restart_cnt", 32'(cycle_count), 32'd0);

      // Randomized instructions checked against the model.
      for (int n = 0; n < 150; n++) begin
         v.imem_dly = $urandom_range(0, 3);
         v.dmem_dly = $urandom_range(0, 3);
         v.data     = INSTR_W'($urandom);
         v.done     = ($urandom_range(0, 19) == 0);
         r          = $urandom_range(0, 3);
         v.mrd      = (r == 0);
         v.mwr      = (r == 1);
         v.rw       = 1'($urandom);
         v.br       = 1'($urandom);
         v.tk       = 1'($urandom);
         v.jmp      = ($urandom_range(0, 3) == 0);
         v.tgt      = PC_W'($urandom);
         v.exp_pc   = v.done ? m_pc : model_next(m_pc, v);
         applyStimulus(v);
         if (v.done) begin
            r = $urandom_range(0, 2);
            for (int k = 0; k < r; k++) begin
               next_cycle(1'b0);
               checkOutput("rnd_halt_cnt", 32'(cycle_count), 32'(m_cnt));
            end
            do_start();
         end
      end

      // Asynchronous reset while a load is waiting on data memory.
      imem_ready = 1'b1; imem_data = INSTR_W'($urandom);
      next_cycle(1'b1);
      done_ctrl = 1'b0; mem_read = 1'b1; mem_write = 1'b0; reg_write = 1'b1;
      next_cycle(1'b1);
      dmem_ready = 1'b0;
      #1;
      checkOutput("arst_pre_dmem_req", 32'(dmem_req), 32'd1);
      #2;
      reset_n = 1'b0;
      dmem_ready = 1'b1;
      #1;
      checkOutput("arst_dmem_req", 32'(dmem_req), 32'd0);
      checkOutput("arst_busy", 32'(busy), 32'd0);
      checkOutput("arst_rwen", 32'(reg_write_en), 32'd0);
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      #1;
      checkOutput("arst_pc", 32'(pc), 32'd0);
      checkOutput("arst_idle_busy", 32'(busy), 32'd0);
      checkOutput("arst_idle_halted", 32'(halted), 32'd0);
      checkOutput("arst_cnt", 32'(cycle_count), 32'd0);
      checkOutput("arst_imem_req", 32'(imem_req), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
